// File: rtl/instruction_sequencer.sv
// instruction_sequencer: four-state fetch/decode/execute/halt controller.
// It fetches an instruction (opcode in the MSBs, address field in the LSBs),
// then either redirects the program counter (JMP/JZ), parks in HALT, or hands
// the instruction to the datapath and waits for exec_done.
// Every output is decoded from registered state, so no input reaches an
// output through combinational logic.

module instruction_sequencer #(
  parameter int OPW     = 3,
  parameter int AW      = 5,
  parameter int OP_JMP  = 5,
  parameter int OP_JZ   = 6,
  parameter int OP_HALT = 7
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               mem_ready,
  input  logic [OPW+AW-1:0]  mem_rdata,
  input  logic               zero,
  input  logic               exec_done,
  input  logic               resume,
  output logic               mem_req,
  output logic [AW-1:0]      mem_addr,
  output logic [OPW-1:0]     ir_op,
  output logic [AW-1:0]      ir_addr,
  output logic [AW-1:0]      pc,
  output logic               exec_valid,
  output logic               halted
);

  // Control opcodes sized to the opcode field so comparisons stay width-matched.
  localparam logic [OPW-1:0] JMP_CODE  = OPW'(OP_JMP);
  localparam logic [OPW-1:0] JZ_CODE   = OPW'(OP_JZ);
  localparam logic [OPW-1:0] HALT_CODE = OPW'(OP_HALT);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   pc_reg, pc_next;
  logic [OPW-1:0]  ir_op_reg, ir_op_next;
  logic [AW-1:0]   ir_addr_reg, ir_addr_next;

  // State, program counter and instruction register; clear aborts anything in flight.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_reg   <= S_FETCH;
      pc_reg      <= '0;
      ir_op_reg   <= '0;
      ir_addr_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      ir_op_reg   <= ir_op_next;
      ir_addr_reg <= ir_addr_next;
    end
  end

  // Next-state logic: inputs are only looked at in the state that owns them.
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    ir_op_next   = ir_op_reg;
    ir_addr_next = ir_addr_reg;

    unique case (state_reg)
      S_FETCH: begin
        // Without mem_ready the fetch simply repeats with IR and pc held.
        if (mem_ready) begin
          ir_op_next   = mem_rdata[OPW+AW-1:AW];
          ir_addr_next = mem_rdata[AW-1:0];
          pc_next      = pc_reg + AW'(1); // wraps naturally at 2^AW
          state_next   = S_DECODE;
        end
      end

      S_DECODE: begin
        // Decode always lasts exactly one cycle.
        if (ir_op_reg == HALT_CODE) begin
          state_next = S_HALT;
        end else if (ir_op_reg == JMP_CODE) begin
          pc_next    = ir_addr_reg;
          state_next = S_FETCH;
        end else if (ir_op_reg == JZ_CODE) begin
          if (zero) begin
            pc_next = ir_addr_reg;
          end
          state_next = S_FETCH;
        end else begin
          state_next = S_EXEC;
        end
      end

      S_EXEC: begin
        if (exec_done) begin
          state_next = S_FETCH;
        end
      end

      S_HALT: begin
        // pc already points past the HALT, so resuming continues in sequence.
        if (resume) begin
          state_next = S_FETCH;
        end
      end

      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    mem_req    = 1'b0;
    exec_valid = 1'b0;
    halted     = 1'b0;
    mem_addr   = pc_reg;

    unique case (state_reg)
      S_FETCH:  mem_req = 1'b1;
      S_DECODE: mem_addr = ir_addr_reg;
      S_EXEC: begin
        exec_valid = 1'b1;
        mem_addr   = ir_addr_reg;
      end
      S_HALT:   halted = 1'b1;
      default:  mem_req = 1'b1;
    endcase
  end

  assign pc      = pc_reg;
  assign ir_op   = ir_op_reg;
  assign ir_addr = ir_addr_reg;

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: directed scenarios followed by randomized traffic,
// every cycle compared against a behavioural model of the sequencer.

module tb_instruction_sequencer;

  logic       clk = 1'b0;
  logic       clear;
  logic       mem_ready;
  logic [7:0] mem_rdata;
  logic       zero;
  logic       exec_done;
  logic       resume;
  logic       mem_req;
  logic [4:0] mem_addr;
  logic [2:0] ir_op;
  logic [4:0] ir_addr;
  logic [4:0] pc;
  logic       exec_valid;
  logic       halted;

  int checks = 0;
  int errors = 0;

  // Behavioural model: phase is one of "fetch", "decode", "exec", "halt".
  string m_phase;
  int    m_pc;
  int    m_op;
  int    m_addr;

  instruction_sequencer dut (
    .clk        (clk),
    .clear      (clear),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .zero       (zero),
    .exec_done  (exec_done),
    .resume     (resume),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .ir_op      (ir_op),
    .ir_addr    (ir_addr),
    .pc         (pc),
    .exec_valid (exec_valid),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = "fetch";
    m_pc    = 0;
    m_op    = 0;
    m_addr  = 0;
  endtask

  // One clock of the sequencer's rules, using the inputs present at the edge.
  task automatic model_advance();
    if (m_phase == "fetch") begin
      if (mem_ready) begin
        m_op    = int'(mem_rdata) / 32;
        m_addr  = int'(mem_rdata) % 32;
        m_pc    = (m_pc + 1) % 32;
        m_phase = "decode";
      end
    end else if (m_phase == "decode") begin
      if (m_op == 7) m_phase = "halt";
      else if (m_op == 5) begin m_pc = m_addr; m_phase = "fetch"; end
      else if (m_op == 6) begin if (zero) m_pc = m_addr; m_phase = "fetch"; end
      else m_phase = "exec";
    end else if (m_phase == "exec") begin
      if (exec_done) m_phase = "fetch";
    end else begin
      if (resume) m_phase = "fetch";
    end
  endtask

  task automatic check_all(input string tag);
    bit uses_ir;
    uses_ir = (m_phase == "decode") || (m_phase == "exec");
    check({tag, ".mem_req"},    32'(mem_req),    32'(m_phase == "fetch"));
    check({tag, ".mem_addr"},   32'(mem_addr),   uses_ir ? m_addr : m_pc);
    check({tag, ".ir_op"},      32'(ir_op),      m_op);
    check({tag, ".ir_addr"},    32'(ir_addr),    m_addr);
    check({tag, ".pc"},         32'(pc),         m_pc);
    check({tag, ".exec_valid"}, 32'(exec_valid), 32'(m_phase == "exec"));
    check({tag, ".halted"},     32'(halted),     32'(m_phase == "halt"));
  endtask

  // Advance one clock; inputs were set 1 time unit after the previous edge.
  task automatic step(input string tag);
    @(posedge clk);
    if (!clear) model_reset();
    else model_advance();
    #1;
    check_all(tag);
  endtask

  // Fetch one instruction with no stall, then let DECODE run.
  task automatic fetch_instr(input logic [7:0] instr, input string tag);
    mem_ready = 1'b1;
    mem_rdata = instr;
    step({tag, ".fetch"});
    mem_ready = 1'b0;
    step({tag, ".decode"});
  endtask

  initial begin
    clear     = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    zero      = 1'b0;
    exec_done = 1'b0;
    resume    = 1'b0;
    model_reset();

    // Reset state before any clock edge.
    #1;
    check_all("reset0");
    step("reset_hold1");
    step("reset_hold2");
    clear = 1'b1;

    // Stall three cycles, then load 001_00111.
    step("stall1");
    step("stall2");
    step("stall3");
    check("stall.pc", 32'(pc), 0);
    mem_ready = 1'b1;
    mem_rdata = 8'b001_00111;
    step("stall_load");
    check("stall_load.pc", 32'(pc), 1);
    check("stall_load.ir_addr", 32'(ir_addr), 7);
    mem_ready = 1'b0;
    step("stall_decode");
    check("stall_exec.mem_addr", 32'(mem_addr), 7);
    check("stall_exec.exec_valid", 32'(exec_valid), 1);
    step("exec_wait");
    exec_done = 1'b1;
    step("exec_done");
    exec_done = 1'b0;
    check("after_exec.mem_addr", 32'(mem_addr), 1);

    // Unconditional jump.
    fetch_instr(8'b101_10110, "jmp22");
    check("jmp22.pc", 32'(pc), 22);
    check("jmp22.mem_addr", 32'(mem_addr), 22);

    // JZ not taken, then taken.
    fetch_instr(8'b101_00100, "jmp4a");
    zero = 1'b0;
    fetch_instr(8'b110_00011, "jz_nt");
    check("jz_nt.pc", 32'(pc), 5);
    fetch_instr(8'b101_00100, "jmp4b");
    zero = 1'b1;
    fetch_instr(8'b110_00011, "jz_t");
    check("jz_t.pc", 32'(pc), 3);
    zero = 1'b0;

    // pc wrap from 31.
    fetch_instr(8'b101_11111, "jmp31");
    mem_ready = 1'b1;
    mem_rdata = 8'b000_01010;
    step("wrap_fetch");
    check("wrap.pc", 32'(pc), 0);
    mem_ready = 1'b0;
    step("wrap_decode");
    exec_done = 1'b1;
    step("wrap_exec");
    exec_done = 1'b0;

    // HALT at pc 9; mem_ready pulses must be ignored.
    fetch_instr(8'b101_01001, "jmp9");
    fetch_instr(8'b111_00000, "halt");
    check("halt.halted", 32'(halted), 1);
    check("halt.mem_req", 32'(mem_req), 0);
    mem_ready = 1'b1;
    step("halt_ign1");
    mem_ready = 1'b0;
    step("halt_ign2");
    check("halt_ign.pc", 32'(pc), 10);
    resume = 1'b1;
    step("resume");
    resume = 1'b0;
    check("resume.mem_addr", 32'(mem_addr), 10);

    // Asynchronous reset in the middle of EXEC, checked before any edge.
    mem_ready = 1'b1;
    mem_rdata = 8'b010_00101;
    step("pre_rst_fetch");
    mem_ready = 1'b0;
    step("pre_rst_decode");
    #2;
    clear = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    check("async_rst.pc", 32'(pc), 0);
    check("async_rst.exec_valid", 32'(exec_valid), 0);
    step("async_rst_hold");
    clear = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 8'b011_00001;
    step("first_after_rst");
    check("first_after_rst.pc", 32'(pc), 1);
    mem_ready = 1'b0;

    // Randomized traffic, with occasional mid-cycle resets.
    for (int i = 0; i < 400; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = 8'($urandom);
      zero      = 1'($urandom_range(0, 1));
      exec_done = ($urandom_range(0, 4) < 2);
      resume    = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 49) == 0) begin
        clear = 1'b0;
        #1;
        model_reset();
        check_all("rand_rst");
      end else begin
        clear = 1'b1;
      end
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
